// File: rtl/video_ip_pkg.sv
// Shared types and register field positions for the video frame controller.
package video_ip_pkg;

   typedef enum logic [1:0] {
      WAIT_SOP = 2'd0,
      IN_FRAME = 2'd1,
      PAUSED   = 2'd2
   } state_e;

   // reg0
   localparam int unsigned PAUSE_BIT  = 0;
   localparam int unsigned IRQ_EN_BIT = 1;
   // reg1
   localparam int unsigned EFFECT_LSB = 0;
   localparam int unsigned EFFECT_MSB = 4;
   localparam int unsigned DELETE_LSB = 8;
   localparam int unsigned DELETE_MSB = 9;
   localparam int unsigned QUANT_LSB  = 16;
   localparam int unsigned QUANT_MSB  = 17;
   // reg2
   localparam int unsigned KEY_LSB    = 16;
   localparam int unsigned KEY_MSB    = 31;
   localparam int unsigned MASK_LSB   = 0;
   localparam int unsigned MASK_MSB   = 15;
   // reg3
   localparam int unsigned SUBST_LSB  = 0;
   localparam int unsigned SUBST_MSB  = 15;

   localparam int unsigned DEF_FRAME_PIXELS = 76800;

   typedef struct packed {
      logic [4:0]  effect;
      logic [1:0]  delete_rgb;
      logic [1:0]  quantif;
      logic [15:0] color_key;
      logic [15:0] color_mask;
      logic [15:0] color_subst;
   } cfg_t;

endpackage

// File: rtl/video_frame_ctrl_if.sv
// Camera sink / downstream handshake bundle for the video frame controller.
interface video_frame_ctrl_if;
   logic st_valid;
   logic st_sop;
   logic st_eop;
   logic ds_ready;
   logic st_ready;
   logic beat_pass;

   modport master (
      output st_valid, st_sop, st_eop, ds_ready,
      input  st_ready, beat_pass
   );

   modport slave (
      input  st_valid, st_sop, st_eop, ds_ready,
      output st_ready, beat_pass
   );
endinterface

// File: rtl/video_cfg_shadow.sv
// Effect configuration shadow: live register values are committed to act only at frame boundaries.
module video_cfg_shadow
   import video_ip_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic cfg_wr,
   input  logic boundary,
   input  logic idle,
   input  cfg_t live,
   output cfg_t act
);

   logic pending;
   logic commit;

   assign commit = boundary | (idle & pending);

   // A write landing on a commit edge keeps pending set so it lands at the next boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= 1'b0;
         act     <= '0;
      end else begin
         if (commit) act <= live;
         if (cfg_wr)      pending <= 1'b1;
         else if (commit) pending <= 1'b0;
      end
   end

endmodule

// File: rtl/video_frame_ctrl.sv
// Frame-level controller: SOP alignment, pause, frame-boundary config commit, frame count, irq, sync errors.
// Optional frame-length check enabled by defining FRAME_LEN_CHECK_EN.
module video_frame_ctrl
   import video_ip_pkg::*;
#(
   parameter int unsigned FRAME_CNT_W  = 16,
   parameter int unsigned PIX_CNT_W    = 20,
   parameter int unsigned FRAME_PIXELS = DEF_FRAME_PIXELS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            cfg_reg0,
   input  logic [31:0]            cfg_reg1,
   input  logic [31:0]            cfg_reg2,
   input  logic [31:0]            cfg_reg3,
   input  logic                   cfg_wr,
   input  logic                   irq_ack,
   input  logic                   err_clr,
   video_frame_ctrl_if.slave      st,
   output logic [4:0]             act_effect,
   output logic [1:0]             act_delete_rgb,
   output logic [1:0]             act_quantif,
   output logic [15:0]            act_color_key,
   output logic [15:0]            act_color_mask,
   output logic [15:0]            act_color_subst,
   output logic                   paused,
   output logic                   irq,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic                   sync_err,
   output logic                   len_err
);

   state_e state;
   logic   pause_req, irq_enable;
   logic   ready_c, accept, frame_done, mid_sop;
   logic   irq_pend, irq_pend_next;
   cfg_t   live, act;

   assign pause_req  = cfg_reg0[PAUSE_BIT];
   assign irq_enable = cfg_reg0[IRQ_EN_BIT];

   always_comb begin
      ready_c = 1'b0;
      case (state)
         WAIT_SOP: ready_c = st.ds_ready & ~pause_req;
         IN_FRAME: ready_c = st.ds_ready;
         default:  ready_c = 1'b0;
      endcase
   end

   assign st.st_ready  = ready_c;
   assign accept       = st.st_valid & ready_c;
   assign st.beat_pass = accept & ((state == IN_FRAME) | ((state == WAIT_SOP) & st.st_sop));
   assign frame_done   = accept & st.st_eop &
                         ((state == IN_FRAME) | ((state == WAIT_SOP) & st.st_sop));
   assign mid_sop      = accept & (state == IN_FRAME) & st.st_sop & ~st.st_eop;

   // Frame FSM; paused tracks the state being entered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= WAIT_SOP;
         paused <= 1'b0;
      end else begin
         case (state)
            WAIT_SOP: begin
               if (accept && st.st_sop) begin
                  if (st.st_eop) begin
                     state  <= pause_req ? PAUSED : WAIT_SOP;
                     paused <= pause_req;
                  end else begin
                     state  <= IN_FRAME;
                  end
               end else if (pause_req) begin
                  state  <= PAUSED;
                  paused <= 1'b1;
               end
            end
            IN_FRAME: begin
               if (frame_done) begin
                  state  <= pause_req ? PAUSED : WAIT_SOP;
                  paused <= pause_req;
               end
            end
            PAUSED: begin
               if (!pause_req) begin
                  state  <= WAIT_SOP;
                  paused <= 1'b0;
               end
            end
            default: begin
               state  <= WAIT_SOP;
               paused <= 1'b0;
            end
         endcase
      end
   end

   // Set beats a simultaneous acknowledge/clear
   assign irq_pend_next = (frame_done & irq_enable) ? 1'b1 :
                          irq_ack                   ? 1'b0 : irq_pend;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_count <= '0;
         irq_pend    <= 1'b0;
         irq         <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         if (frame_done) frame_count <= frame_count + FRAME_CNT_W'(1);
         irq_pend <= irq_pend_next;
         irq      <= irq_pend_next & irq_enable;
         if (mid_sop)      sync_err <= 1'b1;
         else if (err_clr) sync_err <= 1'b0;
      end
   end

   assign live = '{
      effect:      cfg_reg1[EFFECT_MSB:EFFECT_LSB],
      delete_rgb:  cfg_reg1[DELETE_MSB:DELETE_LSB],
      quantif:     cfg_reg1[QUANT_MSB:QUANT_LSB],
      color_key:   cfg_reg2[KEY_MSB:KEY_LSB],
      color_mask:  cfg_reg2[MASK_MSB:MASK_LSB],
      color_subst: cfg_reg3[SUBST_MSB:SUBST_LSB]
   };

   video_cfg_shadow u_cfg_shadow (
      .clk      (clk),
      .reset    (reset),
      .cfg_wr   (cfg_wr),
      .boundary (frame_done),
      .idle     ((state == WAIT_SOP) | (state == PAUSED)),
      .live     (live),
      .act      (act)
   );

   assign act_effect      = act.effect;
   assign act_delete_rgb  = act.delete_rgb;
   assign act_quantif     = act.quantif;
   assign act_color_key   = act.color_key;
   assign act_color_mask  = act.color_mask;
   assign act_color_subst = act.color_subst;

`ifdef FRAME_LEN_CHECK_EN
   logic [PIX_CNT_W-1:0] pix_cnt, pix_next;

   // pix_next includes the current beat, so it is the frame length on the EOP beat
   always_comb begin
      pix_next = pix_cnt;
      if (accept) begin
         if ((state == WAIT_SOP) && st.st_sop)
            pix_next = PIX_CNT_W'(1);
         else if (state == IN_FRAME) begin
            if (st.st_sop && !st.st_eop)
               pix_next = PIX_CNT_W'(1);
            else if (pix_cnt != '1)
               pix_next = pix_cnt + PIX_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_cnt <= '0;
         len_err <= 1'b0;
      end else begin
         pix_cnt <= pix_next;
         if (frame_done && (pix_next != PIX_CNT_W'(FRAME_PIXELS))) len_err <= 1'b1;
         else if (err_clr)                                         len_err <= 1'b0;
      end
   end
`else
   logic [PIX_CNT_W-1:0] unused_pix;
   assign unused_pix = PIX_CNT_W'(FRAME_PIXELS);
   assign len_err    = 1'b0;
`endif

   logic unused_bits;
   assign unused_bits = ^{cfg_reg0[31:2], cfg_reg1[31:18], cfg_reg1[15:10],
                          cfg_reg1[7:5], cfg_reg3[31:16]};

endmodule

// File: doc/video_frame_ctrl.md
Name: video_frame_ctrl

Overview:
- Frame-level controller for the video IP datapath. Sits between the Avalon-MM register block, the camera stream sink and the effects/source path.
- Gates the camera sink handshake, aligns streaming to start-of-packet, and commits effect configuration only at frame boundaries so no frame mixes two configurations.
- Implements pause-at-frame-end, frame counting, end-of-frame interrupt and stream sync-error detection.

Parameters:
FRAME_CNT_W, 16, width of the frame counter (wraps).
PIX_CNT_W, 20, width of the per-frame pixel counter.
FRAME_PIXELS, 76800, expected beats per frame (320x240); used only with the optional feature.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low
cfg_reg0  in  32  live reg0: [0] pause_req, [1] irq_enable
cfg_reg1  in  32  live reg1: effect_sel[4:0], delete_rgb[9:8], quantif_level[17:16]
cfg_reg2  in  32  live reg2: color_key[31:16], color_mask[15:0]
cfg_reg3  in  32  live reg3: color_substitute[15:0]
cfg_wr  in  1  one-cycle pulse on any MM write to reg1..reg3
irq_ack  in  1  one-cycle pulse, clears pending interrupt
err_clr  in  1  one-cycle pulse, clears sticky error flags
st_valid  in  1  camera sink valid
st_sop  in  1  camera sink startofpacket
st_eop  in  1  camera sink endofpacket
ds_ready  in  1  downstream (source) ready
st_ready  out  1  ready returned to camera sink
beat_pass  out  1  accepted beat is forwarded to the effects path (not dropped)
act_effect  out  5  committed effect_sel
act_delete_rgb  out  2  committed delete_rgb
act_quantif  out  2  committed quantif_level
act_color_key  out  16  committed color_key
act_color_mask  out  16  committed color_mask
act_color_subst  out  16  committed color_substitute
paused  out  1  high in PAUSED state
irq  out  1  interrupt request
frame_count  out  FRAME_CNT_W  completed frames
sync_err  out  1  sticky: SOP received mid-frame
len_err  out  1  sticky: frame length mismatch (optional feature)

Behaviour:
- Reset (reset=0, asynchronous): state=WAIT_SOP; all act_* = 0; cfg pending=0; frame_count, pixel count, irq pending, sync_err and len_err = 0.
- Accept = st_valid & st_ready.
- States:
  - WAIT_SOP: st_ready = ds_ready & ~pause_req.
    - Accepted beat with st_sop=1 → IN_FRAME, beat_pass=1.
    - Accepted beat with st_sop=0 → beat dropped (beat_pass=0).
    - pause_req=1 → PAUSED.
  - IN_FRAME: st_ready = ds_ready; beat_pass = accept.
    - Accepted st_eop → frame done; go to PAUSED if pause_req else WAIT_SOP.
    - Accepted st_sop (no eop) → set sync_err; stay IN_FRAME; pixel count restarts at 1; aborted frame not counted.
  - PAUSED: st_ready=0, paused=1. pause_req=0 → WAIT_SOP next cycle.
- Single-beat frame: st_sop & st_eop accepted in WAIT_SOP counts as a complete frame; next state per pause_req.
- beat_pass and st_ready are combinational, zero latency; all other outputs are registered.
- Config commit:
  - cfg_wr sets pending.
  - Commit loads all act_* from live cfg_reg1..3 at the clock edge of an accepted EOP beat, or on any cycle in WAIT_SOP/PAUSED while pending=1. Commit clears pending.
  - If cfg_wr coincides with a commit, pending stays 1, so the new values commit at the next boundary.
  - act_* never change while IN_FRAME except on the accepted EOP edge.
- Frame done:
  - frame_count+1, wrapping at 2^FRAME_CNT_W.
  - If irq_enable=1, set irq pending; set wins over a simultaneous irq_ack.
  - irq = irq pending & irq_enable.
- err_clr clears sync_err and len_err; a simultaneous new error wins.
- Deassertion of reset mid-frame: the block resumes in WAIT_SOP and drops beats until the next SOP.

Optional Feature:
FRAME_LEN_CHECK_EN
- Defined:
  - Pixel counter counts accepted beats in a frame (SOP beat = 1), saturating at all-ones.
  - On accepted EOP, if count != FRAME_PIXELS, set len_err.
- Undefined: no pixel counter is built; len_err is tied to 0.

Decomposition:
- Package video_ip_pkg:
  - state enum {WAIT_SOP, IN_FRAME, PAUSED}.
  - Register field bit positions (PAUSE_BIT, IRQ_EN_BIT, EFFECT_LSB/MSB, etc.).
  - Default FRAME_PIXELS.
- Sub-module video_cfg_shadow: pending flag plus act_* registers, with commit and cfg_wr inputs.

Test Plan:
- 4-beat frame (SOP at beat 0, EOP at beat 3), ds_ready=1, irq_enable=1 → beat_pass on all 4 beats; frame_count=1; irq=1 one cycle after EOP; irq_ack → irq=0.
- cfg_wr with effect_sel=5'h04 at beat 1 of a frame → act_effect stays 0 until the EOP edge, then reads 5'h04.
- pause_req=1 mid-frame → remaining beats accepted; PAUSED after EOP; st_ready=0; pause_req=0 → WAIT_SOP; next SOP accepted.
- 3 non-SOP beats then SOP → first 3 beats accepted with beat_pass=0; SOP beat has beat_pass=1.
- SOP at beat 2 of an open frame → sync_err=1; frame_count unchanged until the following EOP; err_clr → sync_err=0.
- With FRAME_LEN_CHECK_EN and FRAME_PIXELS=8: a 7-beat frame → len_err=1; an 8-beat frame after err_clr → len_err=0.
